// File: rtl/i2c_exp_arb_pkg.sv
// Shared types and defaults for the I2C expander register-access arbiter.
package i2c_exp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE,
        ST_GAP
    } arb_state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 200_000;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } arb_op_t;

endpackage

// File: rtl/i2c_exp_rr_pick.sv
// Round-robin winner selection: the first pending requester after last_grant,
// wrapping modulo N_REQ.
module i2c_exp_rr_pick
    import i2c_exp_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDW-1:0]   last_grant,
    output logic             valid,
    output logic [IDW-1:0]   idx
);

    logic [IDW:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest pending one wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (pending[cand[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_expander_arbiter.sv
// Round-robin arbiter sharing one I2C expander register port among N_REQ requesters.
// Optional grant watchdog enabled by defining I2C_EXP_ARB_TIMEOUT_EN.
module i2c_expander_arbiter
    import i2c_exp_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
`ifdef I2C_EXP_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_wr,
    input  logic [N_REQ-1:0]         req_rd,
    input  logic [N_REQ-1:0][7:0]    req_addr,
    input  logic [N_REQ-1:0][7:0]    req_wdata,
    output logic [N_REQ-1:0]         req_done,
    output logic [N_REQ-1:0]         req_err,
    output logic [7:0]               req_rdata,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     wr_reg_rq,
    output logic                     rd_reg_rq,
    output logic [7:0]               reg_addr,
    output logic [7:0]               reg_write_data,
    input  logic [7:0]               reg_read_data,
    input  logic                     reg_action_done
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_t       state, state_next;
    logic [IDW-1:0]   last_grant;
    arb_op_t          op;
    logic [N_REQ-1:0] pending;
    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic [N_REQ-1:0] owner_onehot;
    logic             timeout_hit;

    assign pending = req_wr | req_rd;

    i2c_exp_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

`ifdef I2C_EXP_ARB_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        to_flag;

    assign timeout_hit = (state == ST_ISSUE) && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside ISSUE so every grant starts a fresh watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state != ST_ISSUE) begin
                to_cnt <= '0;
            end else begin
                to_cnt  <= to_cnt + 32'd1;
                to_flag <= timeout_hit && !reg_action_done;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= IDW'(N_REQ - 1);
            grant_id   <= '0;
            op         <= '0;
            req_rdata  <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        op.wr    <= req_wr[pick_idx];
                        op.addr  <= req_addr[pick_idx];
                        op.wdata <= req_wdata[pick_idx];
                    end
                end
                ST_ISSUE: begin
                    if (reg_action_done) begin
                        if (!op.wr) begin
                            req_rdata <= reg_read_data;
                        end
                    end else if (timeout_hit) begin
                        req_rdata <= 8'hFF;
                    end
                end
                ST_DONE: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

    // Downstream signals come only from the latched op, never from requester inputs.
    always_comb begin
        state_next     = state;
        busy           = (state != ST_IDLE);
        wr_reg_rq      = 1'b0;
        rd_reg_rq      = 1'b0;
        reg_addr       = '0;
        reg_write_data = '0;
        req_done       = '0;
        req_err        = '0;
        owner_onehot   = '0;
        owner_onehot[grant_id] = 1'b1;
        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wr_reg_rq      = op.wr;
                rd_reg_rq      = !op.wr;
                reg_addr       = op.addr;
                reg_write_data = op.wdata;
                if (reg_action_done || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                req_done   = owner_onehot;
`ifdef I2C_EXP_ARB_TIMEOUT_EN
                if (to_flag) begin
                    req_err = owner_onehot;
                end
`endif
                state_next = ST_GAP;
            end
            ST_GAP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_expander_arbiter.sv
// Self-checking bench for i2c_expander_arbiter; exercises the watchdog only when
// I2C_EXP_ARB_TIMEOUT_EN is defined.
module tb_i2c_expander_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_wr, req_rd;
    logic [N-1:0][7:0] req_addr, req_wdata;
    logic [N-1:0]    req_done, req_err;
    logic [7:0]      req_rdata;
    logic [1:0]      grant_id;
    logic            busy, wr_reg_rq, rd_reg_rq;
    logic [7:0]      reg_addr, reg_write_data, reg_read_data;
    logic            reg_action_done;

    i2c_expander_arbiter #(
        .N_REQ (N)
`ifdef I2C_EXP_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_wr          (req_wr),
        .req_rd          (req_rd),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_done        (req_done),
        .req_err         (req_err),
        .req_rdata       (req_rdata),
        .grant_id        (grant_id),
        .busy            (busy),
        .wr_reg_rq       (wr_reg_rq),
        .rd_reg_rq       (rd_reg_rq),
        .reg_addr        (reg_addr),
        .reg_write_data  (reg_write_data),
        .reg_read_data   (reg_read_data),
        .reg_action_done (reg_action_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "[TB] time limit");
    end

    typedef struct {
        int         id;
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] dev;
        int         delay;
    } vec_t;

    typedef struct {
        int         id;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic       m_pend  [N];
    logic       m_wr    [N];
    logic [7:0] m_addr  [N];
    logic [7:0] m_wdata [N];
    int         m_last;
    logic [7:0] m_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic wr, input logic rd,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        req_wr[id]    = wr;
        req_rd[id]    = rd;
        req_addr[id]  = addr;
        req_wdata[id] = wdata;
        m_pend[id]    = wr | rd;
        m_wr[id]      = wr;
        m_addr[id]    = addr;
        m_wdata[id]   = wdata;
    endtask

    task automatic clearReq(input int id);
        req_wr[id] = 1'b0;
        req_rd[id] = 1'b0;
        m_pend[id] = 1'b0;
    endtask

    // Reference model: choose the next round-robin winner and queue its expected result.
    task automatic predict(input logic [7:0] dev);
        exp_t e;
        int   w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && m_pend[(m_last + k) % N]) w = (m_last + k) % N;
        end
        if (w >= 0) begin
            e.id    = w;
            e.wr    = m_wr[w];
            e.addr  = m_addr[w];
            e.wdata = m_wdata[w];
            e.rdata = m_wr[w] ? m_rdata : dev;
            m_rdata = e.rdata;
            m_last  = w;
            sb.push_back(e);
        end
    endtask

    // Act as the downstream device for one grant, through DONE and into GAP.
    task automatic serveOne(input int delay, input logic [7:0] dev, output int waited, output int gid);
        exp_t e;
        waited = 0;
        gid    = -1;
        while (!(wr_reg_rq || rd_reg_rq) && waited < 8) begin
            step();
            waited++;
        end
        if (!(wr_reg_rq || rd_reg_rq)) begin
            checkOutput("issue_seen", 32'(wr_reg_rq | rd_reg_rq), 32'd1);
            return;
        end
        if (sb.size() == 0) return;
        e   = sb.pop_front();
        gid = int'(grant_id);
        checkOutput("grant_id", 32'(grant_id), 32'(e.id));
        checkOutput("wr_reg_rq", 32'(wr_reg_rq), 32'(e.wr));
        checkOutput("rd_reg_rq", 32'(rd_reg_rq), 32'(!e.wr));
        checkOutput("reg_addr", 32'(reg_addr), 32'(e.addr));
        checkOutput("reg_write_data", 32'(reg_write_data), 32'(e.wdata));
        req_addr[e.id]  = ~e.addr;
        req_wdata[e.id] = ~e.wdata;
        repeat (delay) step();
        checkOutput("hold_addr", 32'(reg_addr), 32'(e.addr));
        checkOutput("hold_wdata", 32'(reg_write_data), 32'(e.wdata));
        reg_read_data   = dev;
        reg_action_done = 1'b1;
        step();
        reg_action_done = 1'b0;
        reg_read_data   = 8'hEE;
        checkOutput("done_vec", 32'(req_done), 32'(1) << e.id);
        checkOutput("done_rdata", 32'(req_rdata), 32'(e.rdata));
        checkOutput("done_err", 32'(req_err), 32'd0);
        checkOutput("done_dn_low", 32'({wr_reg_rq, rd_reg_rq}), 32'd0);
        step();
        checkOutput("gap_done", 32'(req_done), 32'd0);
        checkOutput("gap_busy", 32'(busy), 32'd1);
        checkOutput("gap_dn_low", 32'({wr_reg_rq, rd_reg_rq}), 32'd0);
        m_pend[e.id] = 1'b0;
    endtask

    vec_t vecs[5];
    int   order[5];
    int   waited, gid;
    logic [N-1:0] seen_done;

    initial begin
        vecs[0] = '{id:2, wr:1'b1, rd:1'b0, addr:8'h03, wdata:8'h5A, dev:8'h77, delay:10};
        vecs[1] = '{id:1, wr:1'b0, rd:1'b1, addr:8'h00, wdata:8'h00, dev:8'hC3, delay:3};
        vecs[2] = '{id:0, wr:1'b1, rd:1'b1, addr:8'h7E, wdata:8'h81, dev:8'h11, delay:1};
        vecs[3] = '{id:3, wr:1'b0, rd:1'b1, addr:8'h10, wdata:8'h99, dev:8'h3C, delay:0};
        vecs[4] = '{id:1, wr:1'b1, rd:1'b0, addr:8'hFF, wdata:8'h00, dev:8'h55, delay:2};
        order   = '{0, 1, 2, 3, 0};

        rst_n           = 1'b0;
        req_wr          = '0;
        req_rd          = '0;
        req_addr        = '0;
        req_wdata       = '0;
        reg_read_data   = 8'hEE;
        reg_action_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
        end
        m_last  = N - 1;
        m_rdata = 8'h00;

        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(req_done), 32'd0);
        checkOutput("rst_grant", 32'(grant_id), 32'd0);
        checkOutput("rst_dn", 32'({wr_reg_rq, rd_reg_rq, reg_addr, reg_write_data}), 32'd0);
        checkOutput("rst_rdata", 32'(req_rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].id, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            predict(vecs[i].dev);
            serveOne(vecs[i].delay, vecs[i].dev, waited, gid);
            checkOutput("latency", 32'(waited), 32'd1);
            clearReq(vecs[i].id);
            step();
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end

        reg_read_data   = 8'h42;
        reg_action_done = 1'b1;
        step();
        reg_action_done = 1'b0;
        reg_read_data   = 8'hEE;
        checkOutput("spurious_done", 32'(req_done), 32'd0);
        checkOutput("spurious_busy", 32'(busy), 32'd0);
        step();
        checkOutput("spurious_done2", 32'(req_done), 32'd0);

        applyStimulus(2, 1'b1, 1'b0, 8'h33, 8'h44);
        step();
        checkOutput("abort_pre_rq", 32'(wr_reg_rq), 32'd1);
        step();
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_wr_rq", 32'(wr_reg_rq), 32'd0);
        checkOutput("abort_addr", 32'(reg_addr), 32'd0);
        checkOutput("abort_grant", 32'(grant_id), 32'd0);
        checkOutput("abort_rdata", 32'(req_rdata), 32'd0);
        clearReq(2);
        m_last  = N - 1;
        m_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = '0;
        repeat (3) begin
            step();
            seen_done = seen_done | req_done;
        end
        checkOutput("abort_no_done", 32'(seen_done), 32'd0);

        for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 1'b1, 8'h40 + 8'(i), 8'(i));
        for (int g = 0; g < 5; g++) begin
            predict(8'h90 + 8'(g));
            serveOne(1, 8'h90 + 8'(g), waited, gid);
            checkOutput("rr_grant", 32'(gid), 32'(order[g]));
            if (g > 0) checkOutput("rr_rearb_wait", 32'(waited), 32'd2);
            applyStimulus(m_last, 1'b0, 1'b1, 8'h50 + 8'(g), 8'h10 + 8'(g));
        end
        for (int i = 0; i < N; i++) clearReq(i);
        step();
        step();
        step();
        checkOutput("end_idle", 32'(busy), 32'd0);

`ifdef I2C_EXP_ARB_TIMEOUT_EN
        applyStimulus(1, 1'b0, 1'b1, 8'h22, 8'h00);
        step();
        begin
            int c;
            c = 1;
            while (req_done == '0 && c < 200) begin
                step();
                c++;
            end
            checkOutput("to_cycle", 32'(c), 32'd51);
        end
        checkOutput("to_done", 32'(req_done), 32'b0010);
        checkOutput("to_err", 32'(req_err), 32'b0010);
        checkOutput("to_rdata", 32'(req_rdata), 32'hFF);
        clearReq(1);
        step();
        checkOutput("to_err_clear", 32'(req_err), 32'd0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
